// File: rtl/instruction_issue_unit_if.sv
// Load/run control and issue-side outputs of the instruction issue unit.
// The master side drives program loading and run requests; the slave side issues words.
interface instruction_issue_unit_if;
    logic        load_en;
    logic [4:0]  load_addr;
    logic [16:0] load_data;
    logic [5:0]  prog_len;
    logic        start;
    logic [16:0] instruction;
    logic        issue_valid;
    logic [4:0]  pc;
    logic        busy;
    logic        done;

    modport master (
        output load_en, load_addr, load_data, prog_len, start,
        input  instruction, issue_valid, pc, busy, done
    );

    modport slave (
        input  load_en, load_addr, load_data, prog_len, start,
        output instruction, issue_valid, pc, busy, done
    );
endinterface

// File: rtl/instruction_issue_unit.sv
// Sequences a preloaded 32-word program onto the core datapath, holding each word for
// ISSUE_CYCLES and inserting HAZARD_BUBBLES bubbles on read-after-write dependencies.
module instruction_issue_unit #(
    parameter int          ISSUE_CYCLES   = 2,
    parameter int          HAZARD_BUBBLES = 2,
    parameter logic [16:0] BUBBLE_INSTR   = 17'b0
) (
    input  logic clock,
    input  logic reset,
    instruction_issue_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, STALL, DONE} state_t;

    localparam logic [3:0] SLOT_LAST   = 4'(ISSUE_CYCLES - 1);
    localparam logic [3:0] BUBBLE_LAST = 4'(HAZARD_BUBBLES - 1);
    localparam bit         HAS_BUBBLES = (HAZARD_BUBBLES > 0);

    logic [16:0] mem [32];

    state_t      state, next_state;
    logic [4:0]  pc_q, next_pc;
    logic [3:0]  cnt, next_cnt;
    logic [5:0]  len_q, next_len;
    logic [1:0]  last_op;
    logic [4:0]  last_rd;
    logic [16:0] instr_q;
    logic        valid_q, busy_q, done_q;

    logic [16:0] nxt_word, issue_word;
    logic        hazard, slot_end, last_slot;

    // Hazard is judged between the word now in its slot and the one that follows it.
    assign nxt_word   = mem[pc_q + 5'd1];
    assign issue_word = mem[next_pc];
    assign hazard     = (last_op != 2'b11) &&
                        ((nxt_word[9:5] == last_rd) || (nxt_word[4:0] == last_rd));
    assign slot_end   = (cnt == SLOT_LAST);
    assign last_slot  = ({1'b0, pc_q} == (len_q - 6'd1));

    always_comb begin
        next_state = state;
        next_pc    = pc_q;
        next_cnt   = cnt;
        next_len   = len_q;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.prog_len == 6'd0) begin
                        next_state = DONE;
                    end else begin
                        next_state = ISSUE;
                        next_pc    = 5'd0;
                        next_cnt   = 4'd0;
                        next_len   = (bus.prog_len > 6'd32) ? 6'd32 : bus.prog_len;
                    end
                end
            end
            ISSUE: begin
                if (slot_end) begin
                    if (last_slot) begin
                        next_state = DONE;
                    end else begin
                        next_pc    = pc_q + 5'd1;
                        next_cnt   = 4'd0;
                        next_state = (hazard && HAS_BUBBLES) ? STALL : ISSUE;
                    end
                end else begin
                    next_cnt = cnt + 4'd1;
                end
            end
            STALL: begin
                if (cnt == BUBBLE_LAST) begin
                    next_state = ISSUE;
                    next_cnt   = 4'd0;
                end else begin
                    next_cnt = cnt + 4'd1;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered from the next-state decode so they line up with the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            pc_q    <= 5'd0;
            cnt     <= 4'd0;
            len_q   <= 6'd0;
            last_op <= 2'b00;
            last_rd <= 5'd0;
            instr_q <= BUBBLE_INSTR;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= next_state;
            pc_q    <= next_pc;
            cnt     <= next_cnt;
            len_q   <= next_len;
            instr_q <= (next_state == ISSUE) ? issue_word : BUBBLE_INSTR;
            valid_q <= (next_state == ISSUE);
            busy_q  <= (next_state == ISSUE) || (next_state == STALL);
            done_q  <= (next_state == DONE);
            if (next_state == ISSUE) begin
                last_op <= issue_word[16:15];
                last_rd <= issue_word[14:10];
            end
        end
    end

    // Program memory survives reset; loads only land while idle.
    always_ff @(posedge clock) begin
        if (!reset && (state == IDLE) && bus.load_en) begin
            mem[bus.load_addr] <= bus.load_data;
        end
    end

    assign bus.instruction = instr_q;
    assign bus.issue_valid = valid_q;
    assign bus.pc          = pc_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_instruction_issue_unit.sv
// Bench for instruction_issue_unit: two configurations driven in lockstep and compared
// cycle by cycle against a trace generated from the program-level issue rules.
module tb_instruction_issue_unit;
    localparam logic [16:0] BUB_A = 17'h00000;
    localparam logic [16:0] BUB_B = 17'h1abcd;

    typedef logic [24:0] vec_t;
    typedef vec_t vq_t[$];

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    instruction_issue_unit_if if_a();
    instruction_issue_unit_if if_b();

    instruction_issue_unit dut_a (.clock(clock), .reset(reset), .bus(if_a));
    instruction_issue_unit #(.ISSUE_CYCLES(1), .HAZARD_BUBBLES(0), .BUBBLE_INSTR(BUB_B))
        dut_b (.clock(clock), .reset(reset), .bus(if_b));

    logic [16:0] mem_m [32];
    logic [4:0]  pc_a_m, pc_b_m;
    int          n_checks, n_fail, done_at_a;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    function automatic vec_t pack(input logic [16:0] i, input logic v, input logic [4:0] p,
                                  input logic b, input logic d);
        return {i, v, p, b, d};
    endfunction

    function automatic vec_t obs(input bit sel_b);
        if (sel_b) return {if_b.instruction, if_b.issue_valid, if_b.pc, if_b.busy, if_b.done};
        return {if_a.instruction, if_a.issue_valid, if_a.pc, if_a.busy, if_a.done};
    endfunction

    function automatic bit raw_hazard(input logic [16:0] prev, input logic [16:0] nxt);
        return (prev[16:15] != 2'b11) &&
               ((nxt[9:5] == prev[14:10]) || (nxt[4:0] == prev[14:10]));
    endfunction

    // Expected per-cycle trace from the cycle after start up to and including the done cycle.
    function automatic vq_t build(input int ic, input int hb, input logic [16:0] bub,
                                  input int len, input logic [4:0] pc_prev);
        vq_t q;
        int  n;
        n = (len > 32) ? 32 : len;
        if (n == 0) begin
            q.push_back(pack(bub, 1'b0, pc_prev, 1'b0, 1'b1));
        end else begin
            for (int i = 0; i < n; i++) begin
                if (i > 0 && hb > 0 && raw_hazard(mem_m[i-1], mem_m[i]))
                    for (int j = 0; j < hb; j++) q.push_back(pack(bub, 1'b0, 5'(i), 1'b1, 1'b0));
                for (int j = 0; j < ic; j++) q.push_back(pack(mem_m[i], 1'b1, 5'(i), 1'b1, 1'b0));
            end
            q.push_back(pack(bub, 1'b0, 5'(n - 1), 1'b0, 1'b1));
        end
        return q;
    endfunction

    task automatic set_in(input logic le, input logic [4:0] la, input logic [16:0] ld,
                          input logic [5:0] pl, input logic st);
        if_a.load_en = le; if_a.load_addr = la; if_a.load_data = ld;
        if_a.prog_len = pl; if_a.start = st;
        if_b.load_en = le; if_b.load_addr = la; if_b.load_data = ld;
        if_b.prog_len = pl; if_b.start = st;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [4:0] a, input logic [16:0] d);
        set_in(1'b1, a, d, 6'd0, 1'b0);
        tick();
        set_in(1'b0, 5'd0, 17'd0, 6'd0, 1'b0);
        mem_m[a] = d;
    endtask

    function automatic logic [16:0] rand_word();
        return {2'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3))};
    endfunction

    // Runs one program; with disturb set, a load and a start are pulsed mid-run.
    task automatic run(input int len, input bit disturb);
        vq_t qa, qb;
        int  n, eff;
        logic [4:0] end_a, end_b;
        vec_t ea, eb;
        qa = build(2, 2, BUB_A, len, pc_a_m);
        qb = build(1, 0, BUB_B, len, pc_b_m);
        eff = (len > 32) ? 32 : len;
        end_a = (eff == 0) ? pc_a_m : 5'(eff - 1);
        end_b = (eff == 0) ? pc_b_m : 5'(eff - 1);
        n = ((qa.size() > qb.size()) ? qa.size() : qb.size()) + 2;
        done_at_a = -1;
        set_in(1'b0, 5'd0, 17'd0, 6'(len), 1'b1);
        for (int k = 0; k < n; k++) begin
            tick();
            set_in(1'b0, 5'd0, 17'd0, 6'd0, 1'b0);
            ea = (k < qa.size()) ? qa[k] : pack(BUB_A, 1'b0, end_a, 1'b0, 1'b0);
            eb = (k < qb.size()) ? qb[k] : pack(BUB_B, 1'b0, end_b, 1'b0, 1'b0);
            check($sformatf("trace_a[%0d] len=%0d", k, len), 32'(obs(1'b0)), 32'(ea));
            check($sformatf("trace_b[%0d] len=%0d", k, len), 32'(obs(1'b1)), 32'(eb));
            if (if_a.done && done_at_a < 0) done_at_a = k + 1;
            if (disturb && k == 1) set_in(1'b1, 5'd0, ~mem_m[0], 6'd0, 1'b1);
        end
        pc_a_m = end_a;
        pc_b_m = end_b;
    endtask

    initial begin
        int len;
        n_checks = 0;
        n_fail   = 0;
        pc_a_m   = 5'd0;
        pc_b_m   = 5'd0;
        reset    = 1'b1;
        set_in(1'b0, 5'd0, 17'd0, 6'd0, 1'b0);
        tick();
        tick();
        check("reset_a", 32'(obs(1'b0)), 32'(pack(BUB_A, 1'b0, 5'd0, 1'b0, 1'b0)));
        check("reset_b", 32'(obs(1'b1)), 32'(pack(BUB_B, 1'b0, 5'd0, 1'b0, 1'b0)));
        reset = 1'b0;
        for (int i = 0; i < 32; i++) load(5'(i), rand_word());

        // Straight-line program, no dependencies
        load(5'd0, 17'b00_00100_00000_00001);
        load(5'd1, 17'b01_00101_00010_00011);
        load(5'd2, 17'b10_00110_00111_01000);
        run(3, 1'b0);
        check("start_to_done", 32'(done_at_a), 32'd7);

        // RAW dependency through r4, then the same with a non-writing opcode
        load(5'd1, 17'b01_00101_00100_00010);
        run(2, 1'b0);
        load(5'd0, 17'b11_00100_00111_00100);
        load(5'd1, 17'b00_00001_00100_00100);
        run(2, 1'b0);

        run(0, 1'b0);
        run(40, 1'b0);
        check("pc_after_len40", 32'(if_a.pc), 32'd31);

        // Abort in the second cycle of slot pc=1, then restart
        load(5'd0, 17'b00_00100_00000_00001);
        load(5'd1, 17'b01_00101_00010_00011);
        load(5'd2, 17'b10_00110_00111_01000);
        set_in(1'b0, 5'd0, 17'd0, 6'd3, 1'b1);
        tick();
        set_in(1'b0, 5'd0, 17'd0, 6'd0, 1'b0);
        tick();
        tick();
        tick();
        check("slot1_pc", 32'(if_a.pc), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_a", 32'(obs(1'b0)), 32'(pack(BUB_A, 1'b0, 5'd0, 1'b0, 1'b0)));
        check("abort_b", 32'(obs(1'b1)), 32'(pack(BUB_B, 1'b0, 5'd0, 1'b0, 1'b0)));
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("no_done_after_abort[%0d]", k), 32'(if_a.done), 32'd0);
        end
        pc_a_m = 5'd0;
        pc_b_m = 5'd0;
        run(3, 1'b0);

        // Load and start while busy must be ignored
        for (int i = 0; i < 8; i++) load(5'(i), rand_word());
        run(8, 1'b1);
        run(8, 1'b0);

        for (int t = 0; t < 12; t++) begin
            len = int'($urandom_range(0, 40));
            for (int i = 0; i < ((len > 32) ? 32 : len); i++) load(5'(i), rand_word());
            run(len, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/instruction_issue_unit.md
INSTRUCTION_ISSUE_UNIT -- requirements
Module: instruction_issue_unit

Interface
REQ-001 Parameter ISSUE_CYCLES, default 2, SHALL set the clock cycles each program instruction is held on the instruction output (range 1..15).
REQ-002 Parameter HAZARD_BUBBLES, default 2, SHALL set the bubble cycles inserted for a read-after-write hazard (range 0..15).
REQ-003 Parameter BUBBLE_INSTR, default 17'b0, SHALL be the 17-bit value driven on instruction when no program instruction is issued.
REQ-004 Port clock, input, 1: sole clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1: reset, synchronous and active-high.
REQ-006 Port load_en, input, 1: writes load_data into program memory at load_addr.
REQ-007 Port load_addr, input, 5: program memory write address.
REQ-008 Port load_data, input, 17: program word {opcode[16:15], rd[14:10], rs1[9:5], rs2[4:0]}.
REQ-009 Port prog_len, input, 6: number of instructions to run (0..32), sampled on an accepted start.
REQ-010 Port start, input, 1: one-cycle run request.
REQ-011 Port instruction, output, 17: instruction word to the core datapath.
REQ-012 Port issue_valid, output, 1: high while instruction carries a program word.
REQ-013 Port pc, output, 5: index of the program word being issued or awaited.
REQ-014 Port busy, output, 1: high in ISSUE and STALL.
REQ-015 Port done, output, 1: one-cycle pulse at run end.

Function
REQ-016 Program memory SHALL be 32 x 17 bits, registered write, asynchronous read; not cleared by reset.
REQ-017 load_en SHALL be honoured only in IDLE; writes in any other state are discarded.
REQ-018 FSM SHALL have four states: IDLE, ISSUE, STALL, DONE.
REQ-019 IDLE: start=1 with prog_len in 1..32 -> ISSUE next cycle with pc=0; start=1 with prog_len=0 -> DONE; otherwise stay.
REQ-020 prog_len values above 32 SHALL be treated as 32.
REQ-021 In ISSUE, instruction SHALL equal mem[pc] and issue_valid=1 for exactly ISSUE_CYCLES consecutive cycles.
REQ-022 At the end of an issue slot, if pc = prog_len-1 -> DONE; otherwise pc increments by 1 and the hazard check of REQ-023 runs on mem[pc+1].
REQ-023 Hazard: last issued opcode != 2'b11 and (next rs1 == last rd or next rs2 == last rd) -> STALL when HAZARD_BUBBLES > 0; otherwise -> ISSUE directly.
REQ-024 STALL SHALL drive instruction=BUBBLE_INSTR, issue_valid=0 for exactly HAZARD_BUBBLES cycles, then -> ISSUE; no re-check after a stall.
REQ-025 The first instruction of a run SHALL never be stalled.
REQ-026 DONE SHALL last one cycle with done=1, instruction=BUBBLE_INSTR, issue_valid=0, then -> IDLE; pc holds its last value until the next start.
REQ-027 start in ISSUE, STALL or DONE SHALL be ignored.
REQ-028 In IDLE, instruction=BUBBLE_INSTR, issue_valid=0, busy=0, done=0.
REQ-029 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-030 Slot and bubble counters SHALL be 4 bits and SHALL NOT wrap within a slot.

Reset
REQ-031 reset=1 SHALL, at the next edge, force IDLE, pc=0, instruction=BUBBLE_INSTR, issue_valid=0, busy=0, done=0, and clear the hazard history and counters.
REQ-032 reset during ISSUE or STALL SHALL abort the run with no done pulse; program memory contents SHALL be retained.
REQ-033 reset SHALL take priority over start and load_en in the same cycle.

Verification
REQ-034 Load mem[0..2] = 00_00100_00000_00001, 01_00101_00010_00011, 10_00110_00111_01000; prog_len=3; start -> each word on instruction for 2 cycles, pc 0,1,2, no bubbles, done pulse 1 cycle after the last slot, 7 cycles start-to-done.
REQ-035 mem[0]=00_00100_00000_00001, mem[1]=01_00101_00100_00010, prog_len=2 -> 2 cycles of BUBBLE_INSTR with issue_valid=0 between the two slots.
REQ-036 mem[0]=11_00100_00111_00100, mem[1] reads register 4 -> no bubble, since opcode 11 does not create a hazard.
REQ-037 prog_len=0 with start -> done high one cycle later, issue_valid never asserted; prog_len=40 -> 32 words issued, pc ends at 31.
REQ-038 Assert reset in the second cycle of slot pc=1 -> next cycle IDLE, pc=0, no done; a restart reissues the unchanged program from mem[0].
REQ-039 load_en and start pulsed while busy -> memory unchanged, run unaffected; run with ISSUE_CYCLES=1, HAZARD_BUBBLES=0 -> one word per cycle, no stalls.
